ram_dp: RTL

- Parametrised simple-dual-port RAM built from registers; successor to the single-port register RAM.
- One write port and one independent read port.
- Read data is registered and qualified by rvalid.
- Selectable read-during-write policy.
- Sequential clear engine wipes memory to a fill value on request; used as working memory behind the datapath.

---
 rtl/ram_dp_if.sv | 26 ++
 rtl/ram_dp.sv | 115 +++++++++++
 2 files changed

// File: rtl/ram_dp_if.sv
// Bus bundle for the simple-dual-port RAM: write port, read port and
// clear-engine control, with the RAM as slave and its user as master.
interface ram_dp_if #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 8
);
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] wa;
  logic [BUS_WIDTH-1:0]     wd;
  logic                     re;
  logic [ADDRESS_WIDTH-1:0] ra;
  logic [BUS_WIDTH-1:0]     rd;
  logic                     rvalid;
  logic                     clr;
  logic                     busy;

  modport master (
    output we, wa, wd, re, ra, clr,
    input  rd, rvalid, busy
  );

  modport slave (
    input  we, wa, wd, re, ra, clr,
    output rd, rvalid, busy
  );
endinterface

// File: rtl/ram_dp.sv
// Simple-dual-port register RAM with a registered read port, selectable
// read-during-write policy and a sequential clear engine that walks every
// address writing FILL while busy is high.
module ram_dp #(
  parameter int                   BUS_WIDTH     = 8,
  parameter int                   ADDRESS_WIDTH = 8,
  parameter bit                   BYPASS        = 1'b1,
  parameter logic [BUS_WIDTH-1:0] FILL          = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  ram_dp_if.slave bus
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] cnt_reg, cnt_next;
  logic [BUS_WIDTH-1:0]     mem [DEPTH];
  logic [BUS_WIDTH-1:0]     rd_reg;
  logic                     rvalid_reg;
  logic                     busy_reg;

  // Internal port strobes after arbitration between user traffic and clear.
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [BUS_WIDTH-1:0]     wr_data;
  logic                     rd_en;
  logic                     bypass_hit;

  // Next-state logic: IDLE serves the user ports, CLEAR owns the write port.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_en      = 1'b0;
    wr_addr    = bus.wa;
    wr_data    = bus.wd;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.clr) begin
          // Traffic presented alongside clr is dropped.
          state_next = CLEAR;
          cnt_next   = '0;
        end else begin
          wr_en = bus.we;
          rd_en = bus.re;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_reg;
        wr_data = FILL;
        if (cnt_reg == '1) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Same-address collision only matters when the write comes from the user.
  assign bypass_hit = BYPASS && wr_en && (bus.wa == bus.ra);

  // FSM state, clear counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next == CLEAR);
    end
  end

  // Storage array; reset wipes every word to FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= FILL;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; rd holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_reg     <= FILL;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= rd_en;
      if (rd_en) begin
        rd_reg <= bypass_hit ? bus.wd : mem[bus.ra];
      end
    end
  end

  assign bus.rd     = rd_reg;
  assign bus.rvalid = rvalid_reg;
  assign bus.busy   = busy_reg;
endmodule
